// File: rtl/zymason_pkg.sv
// Shared types and constants for the 7-segment scan/write sequencer.
// Imported by the dwell counter and the scheduler top.
package zymason_pkg;

    typedef enum logic [1:0] {
        ST_SCAN = 2'b00,
        ST_ADV  = 2'b01,
        ST_WLO  = 2'b10,
        ST_WHI  = 2'b11
    } sched_state_t;

    localparam int DEFAULT_NUM_DIGITS = 10;
    localparam int DWELL_W            = 4;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

endpackage

// File: rtl/zymason_dwell_cnt.sv
// Tick-driven dwell counter: counts enabled ticks and wraps to zero on the tick
// that matches the programmed limit, so the period is limit+1 ticks.
module zymason_dwell_cnt
    import zymason_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [DWELL_W-1:0] limit_i,
    output logic               match_o
);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] count_d;

    assign match_o = (count_q == limit_i);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = match_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/zymason_scan_sched.sv
// Digit-pointer sequencer sharing the display/write path between the auto scan
// and the nibble-write port; drives one-hot enables, write strobes and blanking.
module zymason_scan_sched
    import zymason_pkg::*;
#(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
    parameter int PTR_W      = $clog2(NUM_DIGITS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rw_i,
    input  logic                  sel_i,
    input  logic                  tick_i,
    input  logic [4:0]            spd_i,
    output logic [NUM_DIGITS-1:0] dig_en_o,
    output logic [PTR_W-1:0]      ptr_o,
    output logic                  wr_lo_o,
    output logic                  wr_hi_o,
    output logic                  blank_o,
    output logic [1:0]            st_out_o
);

    sched_state_t     state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic dwell_clr;
    logic dwell_en;
    logic dwell_match;

    // Dwell only runs while idle in SCAN; a write request always wins over an advance.
    assign dwell_en  = (state_q == ST_SCAN) && !rw_i && spd_i[0] && tick_i;
    assign dwell_clr = (state_q != ST_SCAN) || rw_i;

    zymason_dwell_cnt u_dwell (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (dwell_clr),
        .en_i    (dwell_en),
        .limit_i (spd_i[4:1]),
        .match_o (dwell_match)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_lo_o = 1'b0;
        wr_hi_o = 1'b0;
        blank_o = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (rw_i) begin
                    state_d = ST_WLO;
                end else if (dwell_en && dwell_match) begin
                    state_d = ST_ADV;
                end
            end
            ST_ADV: begin
                blank_o = 1'b1;
                ptr_d   = (ptr_q == PTR_W'(NUM_DIGITS - 1)) ? '0 : ptr_q + 1'b1;
                state_d = rw_i ? ST_WLO : ST_SCAN;
            end
            ST_WLO: begin
                wr_lo_o = rw_i && (sel_i == SEL_LO);
                if (!rw_i) begin
                    state_d = ST_SCAN;
                end else if (sel_i == SEL_HI) begin
                    state_d = ST_WHI;
                end
            end
            ST_WHI: begin
                wr_hi_o = rw_i && (sel_i == SEL_HI);
                if (!rw_i) begin
                    state_d = ST_SCAN;
                end else if (sel_i == SEL_LO) begin
                    state_d = ST_ADV;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_SCAN;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig_en
            assign dig_en_o[gi] = (ptr_q == PTR_W'(gi));
        end
    endgenerate

    assign ptr_o    = ptr_q;
    assign st_out_o = state_q;

endmodule

// File: tb/tb_zymason_scan_sched.sv
// Self-checking bench for zymason_scan_sched: per-cycle vector table plus
// hand sequences for scan timing, wrap, disable and mid-write reset.
module tb_zymason_scan_sched;

    localparam int N  = 10;
    localparam int PW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rw = 1'b0, sel = 1'b0, tick = 1'b0;
    logic [4:0]    spd = 5'd0;
    logic [N-1:0]  dig_en;
    logic [PW-1:0] ptr;
    logic          wr_lo, wr_hi, blank;
    logic [1:0]    st_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    zymason_scan_sched dut (
        .clock    (clock),
        .reset    (reset),
        .rw_i     (rw),
        .sel_i    (sel),
        .tick_i   (tick),
        .spd_i    (spd),
        .dig_en_o (dig_en),
        .ptr_o    (ptr),
        .wr_lo_o  (wr_lo),
        .wr_hi_o  (wr_hi),
        .blank_o  (blank),
        .st_out_o (st_out)
    );

    typedef struct {
        logic       rw, sel, tick;
        logic [4:0] spd;
        int         st, ptr, wlo, whi, blk;
    } vec_t;

    vec_t vecs[25];
    vec_t exp_q[$];
    int   ptr_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int p,
                           input int wlo, input int whi, input int blk);
        logic [N-1:0] one_hot;
        one_hot = '0;
        one_hot[p] = 1'b1;
        chk({tag, " st"}, int'(st_out), st);
        chk({tag, " ptr"}, int'(ptr), p);
        chk({tag, " dig_en"}, int'(dig_en), int'(one_hot));
        chk({tag, " wr_lo"}, int'(wr_lo), wlo);
        chk({tag, " wr_hi"}, int'(wr_hi), whi);
        chk({tag, " blank"}, int'(blank), blk);
        $display("[TB] %s st=%0d ptr=%0d dig_en=%b wr_lo=%0d wr_hi=%0d blank=%0d",
                 tag, st_out, ptr, dig_en, wr_lo, wr_hi, blank);
    endtask

    // Drive on the falling edge, then settle so Mealy outputs can be sampled.
    task automatic drive(input logic r, input logic s, input logic t, input logic [4:0] sp);
        @(negedge clock);
        rw = r; sel = s; tick = t; spd = sp;
        #2;
    endtask

    task automatic setv(input int i, input logic r, input logic s, input logic t,
                        input logic [4:0] sp, input int st, input int p,
                        input int wlo, input int whi, input int blk);
        vecs[i] = '{r, s, t, sp, st, p, wlo, whi, blk};
    endtask

    initial begin
        int blanks;
        vec_t v;

        setv( 0, 1,0,0,5'd0, 0,0,0,0,0);
        setv( 1, 1,0,0,5'd0, 2,0,1,0,0);
        setv( 2, 1,0,0,5'd0, 2,0,1,0,0);
        setv( 3, 1,0,0,5'd0, 2,0,1,0,0);
        setv( 4, 1,1,0,5'd0, 2,0,0,0,0);
        setv( 5, 1,1,0,5'd0, 3,0,0,1,0);
        setv( 6, 1,0,0,5'd0, 3,0,0,0,0);
        setv( 7, 1,0,0,5'd0, 1,0,0,0,1);
        setv( 8, 1,0,0,5'd0, 2,1,1,0,0);
        setv( 9, 0,0,0,5'd0, 2,1,0,0,0);
        setv(10, 0,0,1,5'd0, 0,1,0,0,0);
        setv(11, 0,0,1,5'd1, 0,1,0,0,0);
        setv(12, 0,0,0,5'd1, 1,1,0,0,1);
        setv(13, 0,0,0,5'd1, 0,2,0,0,0);
        setv(14, 1,0,1,5'd1, 0,2,0,0,0);
        setv(15, 1,0,0,5'd1, 2,2,1,0,0);
        setv(16, 1,1,1,5'd1, 2,2,0,0,0);
        setv(17, 1,1,1,5'd1, 3,2,0,1,0);
        setv(18, 0,1,0,5'd1, 3,2,0,0,0);
        setv(19, 0,0,0,5'd1, 0,2,0,0,0);
        setv(20, 0,0,1,5'd3, 0,2,0,0,0);
        setv(21, 0,0,0,5'd3, 0,2,0,0,0);
        setv(22, 0,0,1,5'd3, 0,2,0,0,0);
        setv(23, 0,0,0,5'd3, 1,2,0,0,1);
        setv(24, 0,0,0,5'd3, 0,3,0,0,0);

        // Reset state
        #3;
        chk_all("reset", 0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Vector table with scoreboard
        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].rw, vecs[i].sel, vecs[i].tick, vecs[i].spd);
            exp_q.push_back(vecs[i]);
            v = exp_q.pop_front();
            chk_all($sformatf("vec%0d", i), v.st, v.ptr, v.wlo, v.whi, v.blk);
        end

        // Reset asserted mid-WHI at ptr=3
        drive(1, 0, 0, 5'd0);
        drive(1, 1, 0, 5'd0);
        drive(1, 1, 0, 5'd0);
        chk_all("pre_rst_whi", 3, 3, 0, 1, 0);
        reset = 1'b1;
        #1;
        chk_all("rst_mid_whi", 0, 0, 0, 0, 0);
        @(negedge clock);
        rw = 1'b0; sel = 1'b0;
        reset = 1'b0;

        // Auto scan, dwell 1, tick every 8 cycles, 20 ticks
        blanks = 0;
        for (int g = 0; g < 20; g++) begin
            for (int c = 0; c < 8; c++) begin
                drive(0, 0, (c == 0), 5'b00011);
                if (c == 0) ptr_q.push_back(((g + 1) / 2) % N);
                if (blank) blanks++;
            end
            chk($sformatf("scan ptr g%0d", g), int'(ptr), ptr_q.pop_front());
            $display("[TB] scan tick %0d ptr=%0d", g, ptr);
        end
        chk("scan blank cycles", blanks, 10);
        chk("scan wrap dig_en", int'(dig_en), 1);

        // Scan disabled: ticks ignored
        blanks = 0;
        for (int g = 0; g < 10; g++) begin
            for (int c = 0; c < 4; c++) begin
                drive(0, 0, (c == 0), 5'b00010);
                if (blank) blanks++;
            end
        end
        chk("dis ptr", int'(ptr), 0);
        chk("dis blank cycles", blanks, 0);
        $display("[TB] disabled scan ptr=%0d blanks=%0d", ptr, blanks);

        // Advance to ptr=9 with dwell 0, then write commit wraps to 0
        for (int k = 0; k < 9; k++) begin
            drive(0, 0, 1, 5'b00001);
            drive(0, 0, 0, 5'b00001);
            drive(0, 0, 0, 5'b00001);
        end
        chk_all("pre_wrap", 0, 9, 0, 0, 0);
        drive(1, 0, 0, 5'd0);
        chk_all("wrap_scan", 0, 9, 0, 0, 0);
        drive(1, 1, 0, 5'd0);
        chk_all("wrap_wlo", 2, 9, 0, 0, 0);
        drive(1, 0, 0, 5'd0);
        chk_all("wrap_whi", 3, 9, 0, 0, 0);
        drive(1, 0, 0, 5'd0);
        chk_all("wrap_adv", 1, 9, 0, 0, 1);
        drive(1, 0, 0, 5'd0);
        chk_all("wrap_wlo0", 2, 0, 1, 0, 0);
        drive(0, 0, 0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
